// File: rtl/fetch_receive.sv
// fetch_receive: pairs the synchronous i-mem read data with the PC issued one
// cycle earlier, holds the pair stable across decode stalls, squashes
// wrong-path words on a flush and counts instructions accepted by decode.
module fetch_receive #(
    parameter int                      CORE         = 0,
    parameter int                      ADDRESS_BITS = 32,
    parameter int                      DATA_WIDTH   = 32,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
    parameter logic [DATA_WIDTH-1:0]   NOP          = 32'h00000013
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] issue_PC,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    input  logic                    stall,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic                    valid,
    output logic [31:0]             fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        FLUSH
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDRESS_BITS-1:0] pc_reg;
    logic [DATA_WIDTH-1:0]   hold_inst_reg;
    logic [ADDRESS_BITS-1:0] hold_pc_reg;
    logic [31:0]             fetch_count_reg;

    logic                    capture;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   inst_mux;
    logic [ADDRESS_BITS-1:0] pc_mux;
    logic                    valid_mux;

    // Next-state and output selection; flush outranks stall in every state.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        inst_mux   = NOP;
        pc_mux     = pc_reg;
        valid_mux  = 1'b0;
        case (state_reg)
            BOOT: begin
                state_next = flush ? FLUSH : RUN;
            end
            RUN: begin
                inst_mux  = i_mem_data;
                valid_mux = 1'b1;
                if (flush) begin
                    state_next = FLUSH;
                    inst_mux   = NOP;
                    valid_mux  = 1'b0;
                end else if (stall) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                inst_mux  = hold_inst_reg;
                pc_mux    = hold_pc_reg;
                valid_mux = 1'b1;
                if (flush) begin
                    state_next = FLUSH;
                    inst_mux   = NOP;
                    pc_mux     = pc_reg;
                    valid_mux  = 1'b0;
                end else if (!stall) begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                state_next = flush ? FLUSH : RUN;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        accept = valid_mux && !stall;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // pc_reg always tracks the address whose data arrives on i_mem_data.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= issue_PC;
        end
    end

    // Capture the live pair on the cycle decode first stalls it.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_inst_reg <= NOP;
            hold_pc_reg   <= RESET_PC;
        end else if (capture) begin
            hold_inst_reg <= i_mem_data;
            hold_pc_reg   <= pc_reg;
        end
    end

    // Count instructions decode actually took; wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_reg <= '0;
        end else if (accept) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

    assign fetch_count = fetch_count_reg;

    // CORE is only a debug label; every non-negative index drives the same outputs.
    if (CORE >= 0) begin : g_core
        assign instruction = inst_mux;
        assign inst_PC     = pc_mux;
        assign valid       = valid_mux;
    end

endmodule

// File: doc/fetch_receive.md
# fetch_receive

Fetch-stage receive half of the core front end. It pairs the instruction word returned by the synchronous-read instruction memory with the PC that was issued one cycle earlier, then presents the pair to decode. It holds a stable instruction/PC across decode stalls, squashes wrong-path words on a flush, and keeps a count of delivered instructions. It sits between the fetch-issue PC register / i-cache read port and the decode stage.

## Interface
- CORE, 0, core index (debug only)
- RESET_PC, 0, PC value issued out of reset
- ADDRESS_BITS, 32, PC width
- DATA_WIDTH, 32, instruction width
- NOP, 32'h00000013, word emitted when squashing (addi x0,x0,0)

- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- issue_PC  in  ADDRESS_BITS  address presented to i-mem this cycle
- i_mem_data  in  DATA_WIDTH  i-mem read data for the address presented last cycle
- stall  in  1  decode cannot accept; hold current outputs
- flush  in  1  control-flow redirect this cycle; squash in-flight words
- instruction  out  DATA_WIDTH  instruction to decode
- inst_PC  out  ADDRESS_BITS  PC of instruction
- valid  out  1  instruction is a real fetched word
- fetch_count  out  32  number of instructions accepted by decode

## Operation
- pc_q register: pc_q <= issue_PC every non-reset cycle, unconditionally (tracks the address whose data is on i_mem_data). Reset value RESET_PC.
- State machine: BOOT, RUN, HOLD, FLUSH. Reset -> BOOT.
- BOOT: outputs NOP / pc_q / valid=0. Always -> RUN next cycle (flush -> FLUSH; stall ignored).
- RUN: instruction=i_mem_data, inst_PC=pc_q, valid=1 (combinational pass-through of live data).
  - flush -> FLUSH (outputs this cycle forced NOP, valid=0).
  - else stall -> capture current instruction/inst_PC into hold_inst/hold_PC; -> HOLD.
  - else stay RUN.
- HOLD: instruction=hold_inst, inst_PC=hold_PC, valid=1.
  - flush -> FLUSH (outputs this cycle forced NOP, valid=0); hold contents discarded.
  - stall low -> RUN next cycle (decode consumes hold contents this cycle).
  - stall high -> stay HOLD.
- FLUSH: outputs NOP, inst_PC=pc_q, valid=0, for exactly one cycle; -> RUN (a flush asserted again while in FLUSH re-enters FLUSH). Stall ignored.
- Priority: reset > flush > stall.
- fetch_count: +1 on every cycle with valid=1, stall=0, flush=0; wraps 2^32-1 -> 0; reset to 0.

## Timing
- i-mem latency fixed at 1 cycle: issue_PC=A at cycle t => i_mem_data=mem[A] at t+1, inst_PC=A at t+1 in RUN.
- Reset values (while reset high and in BOOT): instruction=NOP, inst_PC=RESET_PC, valid=0, fetch_count=0, hold regs = NOP/RESET_PC.
- First valid word: second cycle after reset deasserts (BOOT occupies first).
- Stall asserted at cycle t in RUN: outputs at t are live; t+1.. show captured values, unchanged for any stall length; stall deasserted at u => outputs at u still held, live data from u+1. Upstream issue is required to hold its PC while stalled so that pc_q/i_mem_data at u+1 correspond to the next instruction.
- Flush at cycle t: valid=0 at t and t+1; valid returns at t+2 with the target word (issue side presents target at t+1).
- Stall and flush same cycle: flush wins.
- Reset mid-HOLD or mid-FLUSH: next cycle BOOT, all outputs at reset values.

## Test plan
- Reset release, RESET_PC=0, mem[0]=32'h00500093, mem[4]=32'h00A00113, issue 0,4,8 -> cycle 1 valid=0/NOP; cycle 2 instr=00500093 PC=0; cycle 3 instr=00A00113 PC=4; fetch_count=2 after cycle 3.
- Stall 3 cycles while PC=8 (mem[8]=32'h002081B3) is on output -> instr/PC stay 002081B3/8 all three cycles and the release cycle; next cycle shows PC=C; fetch_count increments exactly once for PC 8.
- Flush in RUN with target 0x40 (mem[0x40]=32'h00000517) -> valid=0, instr=NOP for 2 cycles, then instr=00000517 PC=0x40.
- Stall and flush asserted together in HOLD -> FLUSH taken, hold discarded, valid=0 two cycles, no count increment.
- Reset asserted during HOLD -> next cycle instr=NOP, PC=RESET_PC, valid=0, fetch_count=0.
- Preload fetch_count near wrap (run 2^32-1 accepts via force) -> one more accept gives 0.
